// File: rtl/fetch_decode_reg_pkg.sv
// +----------------------------------------------------------------------+
// | fetch_decode_reg_pkg : constants shared by the fetch stage and IF/ID |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package fetch_decode_reg_pkg;

  localparam logic [4:0]  EXC_ADEL_CODE = 5'd4;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
  localparam logic [31:0] TEXT_BASE     = 32'h0000_3000;

  // A delay-slot instruction reports its branch's address, which is 4 bytes earlier.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_decode_reg_if.sv
// +----------------------------------------------------------------------+
// | fetch_decode_reg_if : fetch-side inputs and decode-side outputs      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface fetch_decode_reg_if;
  logic        stall;
  logic        flush;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_exception;
  logic        id_is_jump;

  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_exc;
  logic [4:0]  id_exc_code;
  logic        id_bd;
  logic [31:0] id_epc;

  modport master (
    output stall, flush, if_pc, if_instr, if_exception, id_is_jump,
    input  id_valid, id_pc, id_instr, id_exc, id_exc_code, id_bd, id_epc
  );

  modport slave (
    input  stall, flush, if_pc, if_instr, if_exception, id_is_jump,
    output id_valid, id_pc, id_instr, id_exc, id_exc_code, id_bd, id_epc
  );
endinterface

`default_nettype wire

// File: rtl/fetch_decode_reg_perf_event_counter.sv
// +----------------------------------------------------------------------+
// | perf_event_counter : free-running enable counter, wraps at 2^WIDTH   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module perf_event_counter #(
  parameter int WIDTH = 32
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             en,
  output logic      [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_decode_reg.sv
// +----------------------------------------------------------------------+
// | fetch_decode_reg : IF/ID pipeline register with stall, flush and     |
// | delay-slot tracking; IFID_PERF_EN enables stall/flush counters.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module fetch_decode_reg
  import fetch_decode_reg_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [4:0]  EXC_ADEL = fetch_decode_reg_pkg::EXC_ADEL_CODE
) (
  input  wire logic        clk,
  input  wire logic        reset,
  fetch_decode_reg_if.slave bus,
  output logic      [31:0] stall_cycles,
  output logic      [31:0] flush_count
);

  logic        valid;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        exc;
  logic [4:0]  exc_code;
  logic        bd;
  logic        bd_pending;

  logic incoming_valid;
  logic exc_next;
  logic jump_now;

  // Fetch signals a hang by presenting PC 0; that cycle becomes a bubble.
  assign incoming_valid = (bus.if_pc != 32'd0);
  assign exc_next       = incoming_valid & bus.if_exception;
  assign jump_now       = valid & bus.id_is_jump;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid      <= 1'b0;
      pc         <= RESET_PC;
      instr      <= NOP_INSTR;
      exc        <= 1'b0;
      exc_code   <= 5'd0;
      bd         <= 1'b0;
      bd_pending <= 1'b0;
    end else if (bus.flush) begin
      valid      <= 1'b0;
      pc         <= RESET_PC;
      instr      <= NOP_INSTR;
      exc        <= 1'b0;
      exc_code   <= 5'd0;
      bd         <= 1'b0;
      bd_pending <= 1'b0;
    end else if (!bus.stall) begin
      valid    <= incoming_valid;
      pc       <= bus.if_pc;
      instr    <= (incoming_valid && !bus.if_exception) ? bus.if_instr : NOP_INSTR;
      exc      <= exc_next;
      exc_code <= exc_next ? EXC_ADEL : 5'd0;
      // A bubble cannot take the delay slot, so it stays owed to the next real instruction.
      if (incoming_valid) begin
        bd         <= jump_now | bd_pending;
        bd_pending <= 1'b0;
      end else begin
        bd         <= 1'b0;
        bd_pending <= jump_now | bd_pending;
      end
    end
  end

  assign bus.id_valid    = valid;
  assign bus.id_pc       = pc;
  assign bus.id_instr    = instr;
  assign bus.id_exc      = exc;
  assign bus.id_exc_code = exc_code;
  assign bus.id_bd       = bd;
  assign bus.id_epc      = epc_of(pc, bd);

`ifdef IFID_PERF_EN
  perf_event_counter #(.WIDTH(32)) u_stall_counter (
    .clk   (clk),
    .reset (reset),
    .en    (bus.stall & ~bus.flush),
    .count (stall_cycles)
  );

  perf_event_counter #(.WIDTH(32)) u_flush_counter (
    .clk   (clk),
    .reset (reset),
    .en    (bus.flush),
    .count (flush_count)
  );
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule

`default_nettype wire
